mem_access_ctrl: RTL
====================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameters SHALL be:
- DMEM_BASE, 32'h0000_1000, lowest legal data-memory byte address.
- DMEM_LIMIT, 32'h0000_1FFF, highest legal data-memory byte address, inclusive.
- TIMEOUT_CYCLES, 16, maximum wait cycles per responder phase; legal range 2..255.

REQ-002 Ports SHALL be:
- clk_i  in  1  sole clock; all state updates on its rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- req_valid_i  in  1  pipeline access request.
- req_ready_o  out  1  block can accept a request.
- req_we_i  in  1  1 = store, 0 = load.
- req_addr_i  in  32  byte address.
- req_wdata_i  in  32  store data.
- req_funct3_i  in  3  RV32I load/store funct3.
- rsp_valid_o  out  1  one-cycle response strobe.
- rsp_rdata_o  out  32  load result.
- rsp_err_o  out  2  00 ok, 01 misaligned/illegal size, 10 out-of-range, 11 timeout.
- mem_addr_o  out  32  data-memory address.
- mem_w_data_o  out  32  data-memory write data.
- mem_w_ena_o  out  1  data-memory write enable.
- mem_r_ena_o  out  1  data-memory read enable.
- mem_sign_mask_o  out  3  data-memory size/sign mask; equals the captured funct3.
- mem_r_data_i  in  32  data-memory read data.
- mem_stall_i  in  1  responder busy/stall.
- busy_o  out  1  transaction in flight.

Function
REQ-003 The FSM SHALL have exactly the states IDLE, ISSUE, WAIT_HI, WAIT_LO and RESP.
REQ-004 req_ready_o SHALL be 1 only in IDLE, and a request SHALL be accepted on the rising edge where req_valid_i and req_ready_o are both 1.
REQ-005 On acceptance the block SHALL capture address, data, we and funct3, and SHALL hold mem_addr_o, mem_w_data_o and mem_sign_mask_o stable until the next acceptance.
REQ-006 The acceptance check SHALL set err 01 when:
- the funct3 is illegal (load: 011, 110, 111; store: anything above 010), or
- the access is misaligned (half with addr[0]=1; word with addr[1:0]≠00).
REQ-007 If no err 01 applies, the check SHALL set err 10 when the address lies outside DMEM_BASE..DMEM_LIMIT.
- Exception: a store with addr[31]=0 and addr[13]=1 (LED region) SHALL be legal.
REQ-008 On an acceptance error the block SHALL go IDLE->RESP directly, with no mem enable asserted and rsp_rdata_o=0.
REQ-009 On a legal acceptance the block SHALL go IDLE->ISSUE.
- In ISSUE it SHALL assert exactly one of mem_w_ena_o (store) or mem_r_ena_o (load) for exactly one cycle.
- It SHALL then go to WAIT_HI.
REQ-010 In WAIT_HI, mem_stall_i=1 SHALL move the FSM to WAIT_LO; mem_stall_i at any time outside WAIT_HI/WAIT_LO SHALL be ignored.
REQ-011 In WAIT_LO, mem_stall_i=0 SHALL move the FSM to RESP, capturing mem_r_data_i into rsp_rdata_o for loads and 0 for stores, with err 00.
REQ-012 A cycle counter SHALL clear on entry to each of WAIT_HI and WAIT_LO and SHALL increment every cycle spent there.
- On reaching TIMEOUT_CYCLES the FSM SHALL go to RESP with err 11 and rsp_rdata_o=0.
- The counter width SHALL be 8 bits, with no wrap before TIMEOUT_CYCLES.
REQ-013 RESP SHALL assert rsp_valid_o for exactly one cycle and then return to IDLE; req_ready_o SHALL be 0 in RESP.
REQ-014 rsp_rdata_o and rsp_err_o SHALL hold their values until the next RESP.
REQ-015 busy_o SHALL be 1 in ISSUE, WAIT_HI and WAIT_LO, and 0 otherwise.
REQ-016 Back-to-back requests SHALL be supported, with the next acceptance no earlier than the cycle after RESP.

Reset
REQ-017 While rst_ni=0 the block SHALL, asynchronously:
- force state=IDLE;
- drive req_ready_o=0, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=00, mem_w_ena_o=0, mem_r_ena_o=0, busy_o=0;
- drive mem_addr_o=0, mem_w_data_o=0, mem_sign_mask_o=000;
- clear the counter.
REQ-018 req_ready_o SHALL rise on the first rising edge after rst_ni goes high.
REQ-019 A reset mid-transaction SHALL abandon the transaction with no rsp_valid_o pulse, and any enable SHALL drop immediately.

Verification
Responder model for REQ-020 to REQ-022: stall rises the cycle after ISSUE, holds 2 cycles, and r_data updates at the edge where stall falls.
REQ-020 Load LW at 0x1004 with responder data 0xDEADBEEF -> mem_r_ena_o high 1 cycle; rsp_valid_o 4 cycles after ISSUE; rdata=0xDEADBEEF; err=00.
REQ-021 Store SB 0xA5 at 0x1003 -> mem_w_ena_o 1 cycle; mem_sign_mask_o=000; mem_addr_o=0x1003; rsp rdata=0, err=00.
REQ-022 Store at LED address 0x2000 -> legal (err 00); load at 0x2000 -> err 10, no enable.
REQ-023 Error paths with no mem enable and rsp the cycle after acceptance:
- LH at 0x1001 -> err 01.
- LW at 0x0FFC -> err 10.
- funct3=011 -> err 01.
REQ-024 Stall never rises -> err 11 after TIMEOUT_CYCLES=16 cycles in WAIT_HI; stall stuck high -> err 11 from WAIT_LO.
REQ-025 rst_ni low during WAIT_LO -> outputs immediately at reset values, no rsp_valid_o; after release a new LW completes normally.

Source files
------------

// File: rtl/mem_access_ctrl_if.sv
// Load/store port bundle between the pipeline, the access controller and
// the data memory. The controller uses the slave view; the pipeline/memory
// side (or a bench) uses the master view.
interface mem_access_ctrl_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic [2:0]  req_funct3_i;
  logic        rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic [1:0]  rsp_err_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_w_data_o;
  logic        mem_w_ena_o;
  logic        mem_r_ena_o;
  logic [2:0]  mem_sign_mask_o;
  logic [31:0] mem_r_data_i;
  logic        mem_stall_i;
  logic        busy_o;

  modport slave (
    input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_funct3_i,
    input  mem_r_data_i, mem_stall_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    output mem_addr_o, mem_w_data_o, mem_w_ena_o, mem_r_ena_o, mem_sign_mask_o,
    output busy_o
  );

  modport master (
    output req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_funct3_i,
    output mem_r_data_i, mem_stall_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    input  mem_addr_o, mem_w_data_o, mem_w_ena_o, mem_r_ena_o, mem_sign_mask_o,
    input  busy_o
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// RV32I data-memory access controller. Accepts one load/store at a time,
// screens it for size/alignment/range errors, issues a single-cycle memory
// enable, then follows the responder's stall-high/stall-low handshake with a
// per-phase timeout. Every output is driven straight from a flop.
module mem_access_ctrl #(
  parameter logic [31:0] DMEM_BASE      = 32'h0000_1000,
  parameter logic [31:0] DMEM_LIMIT     = 32'h0000_1FFF,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input logic              clk_i,
  input logic              rst_ni,
  mem_access_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT_HI = 3'd2,
    WAIT_LO = 3'd3,
    RESP    = 3'd4
  } state_e;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_ALIGN   = 2'b01;
  localparam logic [1:0] ERR_RANGE   = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  // Last counter value of a wait phase; the phase lasts TIMEOUT_CYCLES cycles.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 32'd1);

  // Loads allow 000/001/010/100/101; stores allow 000/001/010 only.
  function automatic logic funct3_illegal(input logic we, input logic [2:0] f3);
    logic bad;
    if (we) begin
      bad = (f3 > 3'b010);
    end else begin
      bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    end
    return bad;
  endfunction

  // funct3[1:0] encodes the access size: 00 byte, 01 half, 10 word.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
    logic bad;
    case (f3[1:0])
      2'b01:   bad = a[0];
      2'b10:   bad = (a != 2'b00);
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

  // Outside the data window is an error, except stores into the LED region.
  function automatic logic out_of_range(input logic we, input logic [31:0] a);
    logic bad;
    if ((a < DMEM_BASE) || (a > DMEM_LIMIT)) begin
      bad = !(we && !a[31] && a[13]);
    end else begin
      bad = 1'b0;
    end
    return bad;
  endfunction

  state_e      state_r, state_nxt_s;
  logic [7:0]  cnt_r, cnt_nxt_s;
  logic [1:0]  acc_err_s;
  logic        accept_s;
  logic        rsp_load_s;
  logic [1:0]  rsp_err_nxt_s;
  logic [31:0] rsp_rdata_nxt_s;

  logic        we_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic [2:0]  funct3_r;

  logic        ready_r;
  logic        rsp_valid_r;
  logic        w_ena_r;
  logic        r_ena_r;
  logic        busy_r;
  logic [1:0]  rsp_err_r;
  logic [31:0] rsp_rdata_r;

  // Classify the incoming request; alignment/size errors take precedence over range.
  always_comb begin
    acc_err_s = ERR_OK;
    if (funct3_illegal(bus.req_we_i, bus.req_funct3_i) ||
        misaligned(bus.req_funct3_i, bus.req_addr_i[1:0])) begin
      acc_err_s = ERR_ALIGN;
    end else if (out_of_range(bus.req_we_i, bus.req_addr_i)) begin
      acc_err_s = ERR_RANGE;
    end else begin
      acc_err_s = ERR_OK;
    end
  end

  // Next-state logic plus the response value to latch when entering RESP.
  always_comb begin
    state_nxt_s     = state_r;
    accept_s        = 1'b0;
    rsp_load_s      = 1'b0;
    rsp_err_nxt_s   = ERR_OK;
    rsp_rdata_nxt_s = 32'h0000_0000;
    case (state_r)
      IDLE: begin
        if (bus.req_valid_i && ready_r) begin
          accept_s = 1'b1;
          if (acc_err_s != ERR_OK) begin
            state_nxt_s   = RESP;
            rsp_load_s    = 1'b1;
            rsp_err_nxt_s = acc_err_s;
          end else begin
            state_nxt_s = ISSUE;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ISSUE: begin
        state_nxt_s = WAIT_HI;
      end
      WAIT_HI: begin
        if (bus.mem_stall_i) begin
          state_nxt_s = WAIT_LO;
        end else if (cnt_r >= CNT_LAST) begin
          state_nxt_s   = RESP;
          rsp_load_s    = 1'b1;
          rsp_err_nxt_s = ERR_TIMEOUT;
        end else begin
          state_nxt_s = WAIT_HI;
        end
      end
      WAIT_LO: begin
        if (!bus.mem_stall_i) begin
          state_nxt_s     = RESP;
          rsp_load_s      = 1'b1;
          rsp_err_nxt_s   = ERR_OK;
          rsp_rdata_nxt_s = we_r ? 32'h0000_0000 : bus.mem_r_data_i;
        end else if (cnt_r >= CNT_LAST) begin
          state_nxt_s   = RESP;
          rsp_load_s    = 1'b1;
          rsp_err_nxt_s = ERR_TIMEOUT;
        end else begin
          state_nxt_s = WAIT_LO;
        end
      end
      RESP: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Wait-phase counter: zero on entering a phase, counts while staying in it.
  always_comb begin
    if ((state_nxt_s == state_r) && ((state_r == WAIT_HI) || (state_r == WAIT_LO))) begin
      cnt_nxt_s = cnt_r + 8'd1;
    end else begin
      cnt_nxt_s = 8'd0;
    end
  end

  // State and wait counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= IDLE;
      cnt_r   <= 8'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Capture the accepted request; held until the next acceptance.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      we_r     <= 1'b0;
      addr_r   <= 32'h0000_0000;
      wdata_r  <= 32'h0000_0000;
      funct3_r <= 3'b000;
    end else if (accept_s) begin
      we_r     <= bus.req_we_i;
      addr_r   <= bus.req_addr_i;
      wdata_r  <= bus.req_wdata_i;
      funct3_r <= bus.req_funct3_i;
    end
  end

  // Response payload, updated only on entry to RESP and held afterwards.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_err_r   <= ERR_OK;
      rsp_rdata_r <= 32'h0000_0000;
    end else if (rsp_load_s) begin
      rsp_err_r   <= rsp_err_nxt_s;
      rsp_rdata_r <= rsp_rdata_nxt_s;
    end
  end

  // State-decoded strobes, registered from the next state so they align with it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ready_r     <= 1'b0;
      rsp_valid_r <= 1'b0;
      w_ena_r     <= 1'b0;
      r_ena_r     <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      // ISSUE is only reachable from an acceptance, so req_we_i is the live request.
      ready_r     <= (state_nxt_s == IDLE);
      rsp_valid_r <= (state_nxt_s == RESP);
      w_ena_r     <= (state_nxt_s == ISSUE) && bus.req_we_i;
      r_ena_r     <= (state_nxt_s == ISSUE) && !bus.req_we_i;
      busy_r      <= (state_nxt_s == ISSUE) || (state_nxt_s == WAIT_HI) ||
                     (state_nxt_s == WAIT_LO);
    end
  end

  assign bus.req_ready_o     = ready_r;
  assign bus.rsp_valid_o     = rsp_valid_r;
  assign bus.rsp_rdata_o     = rsp_rdata_r;
  assign bus.rsp_err_o       = rsp_err_r;
  assign bus.mem_addr_o      = addr_r;
  assign bus.mem_w_data_o    = wdata_r;
  assign bus.mem_w_ena_o     = w_ena_r;
  assign bus.mem_r_ena_o     = r_ena_r;
  assign bus.mem_sign_mask_o = funct3_r;
  assign bus.busy_o          = busy_r;

endmodule
